ps2_host_rx: RTL and testbench

Host-side PS/2 receiver that consumes the ps2_clk/ps2_dat waveforms produced by the keyboard model and recovers the scan-code bytes. It synchronises both lines, detects ps2_clk falling edges, and deserialises 11-bit frames: START(0), d0..d7 LSB first, odd PARITY, STOP(1). It checks start, parity and stop, and pushes good bytes into a small show-ahead FIFO. Downstream logic, such as the scan-code decoder or the LED/HEX display path, drains the FIFO over a valid/ready handshake.

---
 rtl/ps2_host_rx_if.sv | 19 +
 rtl/ps2_host_rx.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_host_rx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_rx_if.sv
// rtl/ps2_host_rx_if.sv - received-byte valid/ready stream between the PS/2 receiver and its consumer
//
// Purpose: carries the byte at the head of the receive FIFO to downstream logic.
// Signals:
//   rx_data  [7:0]  byte at the FIFO head, 8'h00 when empty (producer -> consumer)
//   rx_valid        FIFO non-empty (producer -> consumer)
//   rx_ready        consumer accepts rx_data this cycle (consumer -> producer)
// Modports:
//   master  the receiver (drives rx_data/rx_valid)
//   slave   the consumer (drives rx_ready)

interface ps2_host_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/ps2_host_rx.sv
// rtl/ps2_host_rx.sv - host-side PS/2 frame receiver with show-ahead byte FIFO
//
// Purpose: synchronises ps2_clk/ps2_dat, deserialises 11-bit frames
// (start 0, d0..d7 LSB first, odd parity, stop 1) on ps2_clk falling edges,
// checks start/parity/stop and a per-bit timeout, and queues good bytes.
// Ports:
//   Clock       system clock (at least 6x ps2_clk)
//   Resetn      synchronous active-low reset
//   ps2_clk     PS/2 clock line, idles high
//   ps2_dat     PS/2 data line, idles high
//   rx          byte stream out (rx_data/rx_valid/rx_ready), master side
//   parity_err  1-cycle pulse: frame had even parity, byte dropped
//   frame_err   1-cycle pulse: bad start, bad stop or timeout, frame dropped
//   overflow    1-cycle pulse: good byte dropped because the FIFO was full
//   fifo_count  number of bytes currently queued

module ps2_host_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  ps2_host_rx_if.master                 rx,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Line synchronisers and falling-edge detect. Everything resets to 1
  // (the idle level) so leaving reset can never look like a clock edge.
  // ---------------------------------------------------------------------
  logic clk_meta, clk_s, clk_prev;
  logic dat_meta, dat_s;
  logic fall;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      clk_meta <= 1'b1;
      clk_s    <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_s    <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_s    <= clk_meta;
      clk_prev <= clk_s;
      dat_meta <= ps2_dat;
      dat_s    <= dat_meta;
    end
  end

  assign fall = clk_prev & ~clk_s;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic             par, par_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic             timeout;
  logic             push;
  logic             perr_nxt, ferr_nxt;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state   <= S_IDLE;
      shift   <= 8'h00;
      bit_cnt <= 3'd0;
      par     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      par     <= par_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  // The counter would reach TIMEOUT_CYCLES on this edge: abort instead.
  assign timeout = (state != S_IDLE) && !fall &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    par_nxt     = par;
    tmo_nxt     = '0;
    push        = 1'b0;
    perr_nxt    = 1'b0;
    ferr_nxt    = 1'b0;

    if (state != S_IDLE && !fall) begin
      tmo_nxt = tmo_cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (fall) begin
          if (!dat_s) begin
            state_nxt   = S_DATA;
            bit_cnt_nxt = 3'd0;
          end else begin
            ferr_nxt = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_nxt   = {dat_s, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_nxt   = dat_s;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_nxt = S_IDLE;
          // frame_err wins over parity_err; one pulse per frame at most
          if (!dat_s) begin
            ferr_nxt = 1'b1;
          end else if (^{shift, par} == 1'b0) begin
            perr_nxt = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (timeout) begin
      state_nxt = S_IDLE;
      ferr_nxt  = 1'b1;
      tmo_nxt   = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead FIFO. A push while full is still accepted when a pop
  // frees the head slot in the same cycle.
  // ---------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, wr_en, ovf_nxt;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop     = ~empty & rx.rx_ready;
  assign wr_en   = push & (~full | pop);
  assign ovf_nxt = push & full & ~pop;

  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
      overflow   <= ovf_nxt;
    end
  end

  assign rx.rx_valid = ~empty;
  assign rx.rx_data  = empty ? 8'h00 : mem[rd_ptr];
  assign fifo_count  = count;

endmodule

// File: tb/tb_ps2_host_rx.sv
// tb/tb_ps2_host_rx.sv - directed table-driven bench for ps2_host_rx

module tb_ps2_host_rx;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       parity_err, frame_err, overflow;
  logic [3:0] fifo_count;

  ps2_host_rx_if rx_if ();

  ps2_host_rx #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(64)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rx         (rx_if),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 Clock = ~Clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Monitor: accepted bytes and pulse-cycle counts
  logic [7:0] got[$];
  int perr_n = 0;
  int ferr_n = 0;
  int ovf_n  = 0;

  always @(negedge Clock) begin
    if (Resetn) begin
      if (rx_if.rx_valid && rx_if.rx_ready) got.push_back(rx_if.rx_data);
      if (parity_err) perr_n <= perr_n + 1;
      if (frame_err)  ferr_n <= ferr_n + 1;
      if (overflow)   ovf_n  <= ovf_n + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Sends bits[0..n-1], one per ps2_clk low pulse; data set up 4 cycles
  // before the falling edge. With chk_lat the stop-bit edge latency is checked.
  task automatic send_bits(input logic [10:0] bits, input int n,
                           input logic chk_lat, input logic [7:0] exp_byte);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      ps2_dat = bits[i];
      repeat (4) @(negedge Clock);
      ps2_clk = 1'b0;
      if (chk_lat && i == 10) begin
        repeat (2) @(negedge Clock);
        check("lat_valid_cycle_n", rx_if.rx_valid, 0);
        @(negedge Clock);
        check("lat_valid_cycle_n1", rx_if.rx_valid, 1);
        check("lat_data_cycle_n1", rx_if.rx_data, exp_byte);
        @(negedge Clock);
        check("lat_popped_valid", rx_if.rx_valid, 0);
        check("lat_popped_count", fifo_count, 0);
        repeat (4) @(negedge Clock);
      end else begin
        repeat (8) @(negedge Clock);
      end
      ps2_clk = 1'b1;
      repeat (3) @(negedge Clock);
    end
    ps2_dat = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_byte;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int b, p, f, o;

    // parity bits hand-computed for odd parity
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // even parity
    vecs[3] = '{8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};  // stop bit 0
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rx_if.rx_ready = 1'b0;
    Resetn = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_valid", rx_if.rx_valid, 0);
    check("rst_data", rx_if.rx_data, 8'h00);
    check("rst_count", fifo_count, 0);
    check("rst_pulses", {parity_err, frame_err, overflow}, 0);
    Resetn = 1'b1;
    repeat (5) @(negedge Clock);
    check("post_rst_pulses", {parity_err, frame_err, overflow}, 0);

    // Exact latency on a 1C frame
    rx_if.rx_ready = 1'b1;
    p = perr_n; f = ferr_n;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 11, 1'b1, 8'h1C);
    repeat (4) @(negedge Clock);
    check("lat_no_errs", (perr_n - p) + (ferr_n - f), 0);

    // Table of single frames, consumer always ready
    foreach (vecs[k]) begin
      rx_if.rx_ready = 1'b1;
      b = got.size(); p = perr_n; f = ferr_n;
      send_bits({vecs[k].stop, vecs[k].par, vecs[k].data, 1'b0}, 11, 1'b0, 8'h00);
      repeat (4) @(negedge Clock);
      check($sformatf("vec%0d_nbytes", k), got.size() - b, vecs[k].exp_byte);
      if (vecs[k].exp_byte && got.size() > b)
        check($sformatf("vec%0d_byte", k), got[b], vecs[k].data);
      check($sformatf("vec%0d_perr", k), perr_n - p, vecs[k].exp_perr);
      check($sformatf("vec%0d_ferr", k), ferr_n - f, vecs[k].exp_ferr);
      check($sformatf("vec%0d_count", k), fifo_count, 0);
    end

    // Ordering with back-pressure: F0 then 1C
    rx_if.rx_ready = 1'b0;
    b = got.size();
    send_bits({1'b1, 1'b1, 8'hF0, 1'b0}, 11, 1'b0, 8'h00);
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 11, 1'b0, 8'h00);
    repeat (4) @(negedge Clock);
    check("order_count", fifo_count, 2);
    check("order_head", rx_if.rx_data, 8'hF0);
    check("order_valid", rx_if.rx_valid, 1);
    rx_if.rx_ready = 1'b1;
    repeat (4) @(negedge Clock);
    check("order_nbytes", got.size() - b, 2);
    if (got.size() >= b + 2) begin
      check("order_first", got[b], 8'hF0);
      check("order_second", got[b+1], 8'h1C);
    end
    check("order_empty_data", rx_if.rx_data, 8'h00);

    // Timeout after start + 4 data bits, then a good 5A
    f = ferr_n;
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, 1'b0, 8'h00);
    repeat (50) @(negedge Clock);
    check("tmo_not_yet", ferr_n - f, 0);
    repeat (50) @(negedge Clock);
    check("tmo_ferr", ferr_n - f, 1);
    check("tmo_count", fifo_count, 0);
    b = got.size(); f = ferr_n;
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 11, 1'b0, 8'h00);
    repeat (4) @(negedge Clock);
    check("tmo_next_nbytes", got.size() - b, 1);
    if (got.size() > b) check("tmo_next_byte", got[b], 8'h5A);
    check("tmo_next_ferr", ferr_n - f, 0);

    // Overflow: nine frames into an 8-deep FIFO
    rx_if.rx_ready = 1'b0;
    o = ovf_n;
    for (int i = 1; i <= 9; i++) begin
      logic [7:0] d;
      d = 8'(i);
      send_bits({1'b1, ~^d, d, 1'b0}, 11, 1'b0, 8'h00);
      if (i == 8) check("ovf_none_before_9th", ovf_n - o, 0);
    end
    repeat (4) @(negedge Clock);
    check("ovf_count_full", fifo_count, 8);
    check("ovf_pulses", ovf_n - o, 1);
    check("ovf_head", rx_if.rx_data, 8'h01);
    b = got.size();
    rx_if.rx_ready = 1'b1;
    repeat (12) @(negedge Clock);
    check("ovf_drain_n", got.size() - b, 8);
    for (int i = 0; i < 8; i++)
      if (got.size() > b + i) check($sformatf("ovf_drain_%0d", i), got[b+i], 8'(i + 1));
    check("ovf_drain_count", fifo_count, 0);

    // Reset mid-frame after 5 bits
    b = got.size(); p = perr_n; f = ferr_n;
    send_bits({1'b1, 1'b0, 8'hE7, 1'b0}, 5, 1'b0, 8'h00);
    @(negedge Clock);
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 11, 1'b0, 8'h00);
    repeat (80) @(negedge Clock);
    check("mid_rst_nbytes", got.size() - b, 1);
    if (got.size() > b) check("mid_rst_byte", got[b], 8'h1C);
    check("mid_rst_perr", perr_n - p, 0);
    check("mid_rst_ferr", ferr_n - f, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
